pipe_stage_elastic: RTL and testbench

- Parametrised pipeline stage register for the RISC-V core: the generic successor to the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data bundle and a control bundle with a valid/ready handshake.
- Provides separate hold (freeze, contents kept) and flush (insert bubble) controls.
- Optional skid buffer registers in_ready; saturating stall/flush counters support hazard-unit debug.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/pipe_sat_counter.sv | 19 +
 rtl/pipe_stage_elastic.sv | 181 ++++++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers:
// EX/MEM control layout, data bundle offsets and skid-buffer states.
package pipe_pkg;

    // EX/MEM control bundle bit positions
    localparam int unsigned ESC_REG = 0;
    localparam int unsigned ESC_MEM = 1;
    localparam int unsigned JUMP    = 2;
    localparam int unsigned BRANCH  = 3;
    localparam int unsigned JALR    = 4;
    localparam int unsigned LW      = 5;

    localparam int unsigned CTRL_W_EXMEM      = 8;
    localparam logic [7:0]  CTRL_BUBBLE_EXMEM = 8'h00;

    // Data bundle field layout (32-bit fields, LSB first)
    localparam int unsigned FIELD_W     = 32;
    localparam int unsigned OFF_RS2     = 0;
    localparam int unsigned OFF_IMM_PC  = 32;
    localparam int unsigned OFF_PC_ADD4 = 64;
    localparam int unsigned OFF_ALU_OUT = 96;

    typedef enum logic [1:0] {
        SK_EMPTY = 2'd0,
        SK_ONE   = 2'd1,
        SK_TWO   = 2'd2
    } skid_state_t;

    // True when a control word cannot cause any architectural side effect.
    function automatic logic ctrl_is_noop(input logic [CTRL_W_EXMEM-1:0] c);
        return !(c[ESC_REG] | c[ESC_MEM] | c[JUMP] | c[BRANCH] | c[JALR] | c[LW]);
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Parametrised valid/ready pipeline stage register with hold, flush,
// optional skid buffer and saturating stall/flush debug counters.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W      = 128,
    parameter int unsigned        CTRL_W      = 8,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_EXMEM),
    parameter int unsigned        SKID        = 1,
    parameter int unsigned        CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              head_valid;
    logic [DATA_W-1:0] head_data;
    logic [CTRL_W-1:0] head_ctrl;
    logic              accept;
    logic              send;

    assign accept = in_valid & in_ready;
    assign send   = out_valid & out_ready;

    // Hold masks the head beat; invalid heads always present the bubble.
    assign out_valid = head_valid & ~hold;
    assign out_ctrl  = out_valid ? head_ctrl : CTRL_BUBBLE;
    assign out_data  = head_data;

    generate
        if (SKID == 0) begin : g_single
            logic              valid_q;
            logic [DATA_W-1:0] data_q;
            logic [CTRL_W-1:0] ctrl_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    ctrl_q  <= CTRL_BUBBLE;
                end else if (flush) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    ctrl_q  <= CTRL_BUBBLE;
                end else if (accept) begin
                    valid_q <= 1'b1;
                    data_q  <= in_data;
                    ctrl_q  <= in_ctrl;
                end else if (send) begin
                    valid_q <= 1'b0;
                end
            end

            assign in_ready   = (~valid_q | out_ready) & ~hold;
            assign head_valid = valid_q;
            assign head_data  = data_q;
            assign head_ctrl  = ctrl_q;

        end else begin : g_skid
            skid_state_t       state_q;
            skid_state_t       state_d;
            logic              in_ready_q;
            logic [DATA_W-1:0] main_data;
            logic [CTRL_W-1:0] main_ctrl;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;
            logic              ld_main_in;
            logic              ld_main_skid;
            logic              ld_skid;
            logic              clr;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q    <= SK_EMPTY;
                    in_ready_q <= 1'b1;
                end else begin
                    state_q    <= state_d;
                    in_ready_q <= (state_d != SK_TWO);
                end
            end

            // accept/send are already zero under hold, so hold needs no branch here.
            always_comb begin
                state_d      = state_q;
                ld_main_in   = 1'b0;
                ld_main_skid = 1'b0;
                ld_skid      = 1'b0;
                clr          = 1'b0;
                if (flush) begin
                    state_d = SK_EMPTY;
                    clr     = 1'b1;
                end else begin
                    unique case (state_q)
                        SK_EMPTY: begin
                            if (accept) begin
                                state_d    = SK_ONE;
                                ld_main_in = 1'b1;
                            end
                        end
                        SK_ONE: begin
                            if (accept && send) begin
                                ld_main_in = 1'b1;
                            end else if (accept) begin
                                state_d = SK_TWO;
                                ld_skid = 1'b1;
                            end else if (send) begin
                                state_d = SK_EMPTY;
                            end
                        end
                        SK_TWO: begin
                            if (send) begin
                                state_d      = SK_ONE;
                                ld_main_skid = 1'b1;
                            end
                        end
                        default: state_d = SK_EMPTY;
                    endcase
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    main_data <= '0;
                    main_ctrl <= CTRL_BUBBLE;
                    skid_data <= '0;
                    skid_ctrl <= CTRL_BUBBLE;
                end else if (clr) begin
                    main_data <= '0;
                    main_ctrl <= CTRL_BUBBLE;
                    skid_data <= '0;
                    skid_ctrl <= CTRL_BUBBLE;
                end else begin
                    if (ld_main_in) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end else if (ld_main_skid) begin
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                    end
                    if (ld_skid) begin
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                    end
                end
            end

            assign in_ready   = in_ready_q & ~hold;
            assign head_valid = (state_q != SK_EMPTY);
            assign head_data  = main_data;
            assign head_ctrl  = main_ctrl;
        end
    endgenerate

    // The skid entry is only ever valid behind a valid main entry.
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hold | (out_valid & ~out_ready)),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush & head_valid),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench: SKID=1 stage (a_*) and SKID=0, CNT_W=4 stage (b_*).
module tb_pipe_stage_elastic;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_flush, a_hold, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [7:0]  a_in_ctrl, a_out_ctrl;
    logic [15:0] a_stall_cnt, a_flush_cnt;

    logic        b_flush, b_hold, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [7:0]  b_in_ctrl, b_out_ctrl;
    logic [3:0]  b_stall_cnt, b_flush_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    pipe_stage_elastic #(
        .DATA_W(32), .CTRL_W(8), .CTRL_BUBBLE(8'h00), .SKID(1), .CNT_W(16)
    ) dut_a (
        .clk(clk), .reset(reset), .flush(a_flush), .hold(a_hold),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipe_stage_elastic #(
        .DATA_W(32), .CTRL_W(8), .CTRL_BUBBLE(8'h00), .SKID(0), .CNT_W(4)
    ) dut_b (
        .clk(clk), .reset(reset), .flush(b_flush), .hold(b_hold),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_flush = 0; a_hold = 0; a_in_valid = 0; a_out_ready = 1; a_in_data = '0; a_in_ctrl = '0;
        b_flush = 0; b_hold = 0; b_in_valid = 0; b_out_ready = 1; b_in_data = '0; b_in_ctrl = '0;

        // Reset state
        #3;
        chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_a_out_data",  64'(a_out_data),  64'd0);
        chk("rst_a_out_ctrl",  64'(a_out_ctrl),  64'h00);
        chk("rst_a_in_ready",  64'(a_in_ready),  64'd1);
        chk("rst_a_stall",     64'(a_stall_cnt), 64'd0);
        chk("rst_a_flush",     64'(a_flush_cnt), 64'd0);
        chk("rst_b_in_ready",  64'(b_in_ready),  64'd1);
        #4 reset = 1'b0;

        // Streaming 1..8 with out_ready high
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1; a_in_data = 32'(i); a_in_ctrl = 8'h01;
            tick;
            chk("stream_valid", 64'(a_out_valid), 64'd1);
            chk("stream_data",  64'(a_out_data),  64'(i));
            chk("stream_ready", 64'(a_in_ready),  64'd1);
        end
        a_in_valid = 0;
        tick;
        chk("stream_drain_valid", 64'(a_out_valid), 64'd0);
        chk("stream_stall",       64'(a_stall_cnt), 64'd0);

        // Backpressure: A accepted, then 3 cycles of out_ready=0 while B, C offered
        a_in_valid = 1; a_in_data = 32'hA; a_out_ready = 1;
        tick;
        chk("bp_head_A", 64'(a_out_data), 64'hA);
        a_out_ready = 0; a_in_data = 32'hB;
        #1;
        chk("bp_ready_before_B", 64'(a_in_ready), 64'd1);
        tick;
        chk("bp_ready_drop", 64'(a_in_ready), 64'd0);
        chk("bp_head_still_A", 64'(a_out_data), 64'hA);
        a_in_data = 32'hC;
        tick;
        chk("bp_ready_low", 64'(a_in_ready), 64'd0);
        tick;
        chk("bp_head_A_3", 64'(a_out_data),  64'hA);
        chk("bp_stall3",   64'(a_stall_cnt), 64'd3);
        a_out_ready = 1;
        tick;
        chk("bp_order_B",  64'(a_out_data), 64'hB);
        chk("bp_ready_up", 64'(a_in_ready), 64'd1);
        tick;
        chk("bp_order_C",  64'(a_out_data),  64'hC);
        chk("bp_valid_C",  64'(a_out_valid), 64'd1);
        a_in_valid = 0;
        tick;
        chk("bp_drained",  64'(a_out_valid), 64'd0);
        chk("bp_stall_end", 64'(a_stall_cnt), 64'd3);

        // Hold for 4 cycles with 0xABCD held (fresh counters)
        reset = 1; #2; reset = 0;
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'hABCD; a_in_ctrl = 8'h05;
        tick;
        a_in_data = 32'h1111; a_hold = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("hold_out_valid", 64'(a_out_valid), 64'd0);
            chk("hold_in_ready",  64'(a_in_ready),  64'd0);
            chk("hold_ctrl_bub",  64'(a_out_ctrl),  64'h00);
            tick;
        end
        a_hold = 0; a_in_valid = 0;
        #1;
        chk("hold_rel_valid", 64'(a_out_valid), 64'd1);
        chk("hold_rel_data",  64'(a_out_data),  64'hABCD);
        chk("hold_rel_ctrl",  64'(a_out_ctrl),  64'h05);
        chk("hold_stall4",    64'(a_stall_cnt), 64'd4);
        a_out_ready = 1;
        tick;
        chk("hold_sent", 64'(a_out_valid), 64'd0);

        // Flush together with hold while two beats (ctrl 3F) are held
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'h11; a_in_ctrl = 8'h3F;
        tick;
        a_in_data = 32'h22;
        tick;
        chk("fl_pre_ctrl",  64'(a_out_ctrl), 64'h3F);
        chk("fl_pre_ready", 64'(a_in_ready), 64'd0);
        a_flush = 1; a_hold = 1; a_in_data = 32'h33;
        tick;
        a_flush = 0; a_hold = 0; a_in_valid = 0;
        #1;
        chk("fl_valid",  64'(a_out_valid), 64'd0);
        chk("fl_ctrl",   64'(a_out_ctrl),  64'h00);
        chk("fl_data",   64'(a_out_data),  64'd0);
        chk("fl_cnt",    64'(a_flush_cnt), 64'd1);
        chk("fl_ready",  64'(a_in_ready),  64'd1);
        a_out_ready = 1;
        tick;
        chk("fl_beat_absent", 64'(a_out_valid), 64'd0);
        a_flush = 1;
        tick;
        a_flush = 0;
        chk("fl_empty_nocount", 64'(a_flush_cnt), 64'd1);

        // Asynchronous reset between edges while in TWO
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'h44;
        tick;
        a_in_data = 32'h55;
        tick;
        chk("mr_two_ready", 64'(a_in_ready),  64'd0);
        chk("mr_two_valid", 64'(a_out_valid), 64'd1);
        a_in_valid = 0;
        #2;
        reset = 1;
        #1;
        chk("mr_valid", 64'(a_out_valid), 64'd0);
        chk("mr_ctrl",  64'(a_out_ctrl),  64'h00);
        chk("mr_data",  64'(a_out_data),  64'd0);
        chk("mr_stall", 64'(a_stall_cnt), 64'd0);
        chk("mr_flush", 64'(a_flush_cnt), 64'd0);
        chk("mr_ready", 64'(a_in_ready),  64'd1);
        #1 reset = 0;

        // SKID=0, CNT_W=4: stall counter saturation
        b_hold = 1;
        for (int k = 0; k < 15; k++) tick;
        chk("sat_15", 64'(b_stall_cnt), 64'd15);
        for (int k = 0; k < 5; k++) tick;
        chk("sat_20", 64'(b_stall_cnt), 64'd15);
        b_hold = 0; b_out_ready = 1;

        // SKID=0 simultaneous send and accept each cycle
        for (int i = 0; i < 6; i++) begin
            b_in_valid = 1; b_in_data = 32'h100 + 32'(i); b_in_ctrl = 8'h21;
            #1;
            chk("s0_ready", 64'(b_in_ready), 64'd1);
            tick;
            chk("s0_valid", 64'(b_out_valid), 64'd1);
            chk("s0_data",  64'(b_out_data),  64'h100 + 64'(i));
            chk("s0_ctrl",  64'(b_out_ctrl),  64'h21);
        end
        b_in_valid = 0; b_out_ready = 0;
        #1;
        chk("s0_ready_blocked", 64'(b_in_ready), 64'd0);
        tick;
        chk("s0_kept_valid", 64'(b_out_valid), 64'd1);
        chk("s0_kept_data",  64'(b_out_data),  64'h105);
        b_out_ready = 1;
        tick;
        chk("s0_empty_valid", 64'(b_out_valid), 64'd0);
        chk("s0_empty_ctrl",  64'(b_out_ctrl),  64'h00);
        chk("s0_stall_sat",   64'(b_stall_cnt), 64'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
